// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector front end: serializer FSM
// state encodings and the default idle fill bit shared with the detector bench.
package seq_pkg;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_e;

  // Value driven on the serial line while no word is shifting.
  localparam logic SEQ_IDLE_BIT = 1'b0;

endpackage : seq_pkg

// File: rtl/seq_bit_serializer_if.sv
// Parallel-in / serial-out bus of the bit serializer. The master side offers
// words and watches the serial stream; the slave side is the serializer.
interface seq_bit_serializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_bit;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  ser_bit,
    input  ser_valid,
    input  ser_last,
    input  busy
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output ser_bit,
    output ser_valid,
    output ser_last,
    output busy
  );

endinterface : seq_bit_serializer_if

// File: rtl/seq_skid_reg.sv
// One-entry hold (skid) register. Captures a word on i_load and releases it
// on i_drain; o_full tells the owner whether o_data is meaningful.
module seq_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_drain,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  // Occupancy flag: set on load, cleared on drain, cleared by reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  // Data capture on load only.
  // NOTE: the data word is deliberately not reset; it is only ever consumed
  // while r_full is set, so resetting it would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule : seq_skid_reg

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial converter feeding the sequence detector's inp_bit.
// Words arrive on a valid/ready handshake and leave one bit per clock with
// no gap between consecutive words; a one-entry skid register absorbs the
// word offered while the shifter is still busy.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = SEQ_IDLE_BIT
) (
  input  logic clk,
  input  logic reset,
  seq_bit_serializer_if.slave bus
);

  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  // Words are stored pre-ordered so the shifter always emits its MSB and
  // shifts left, whatever the bit order on the wire.
  function automatic logic [WIDTH-1:0] f_order(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] v;
    if (MSB_FIRST) begin
      v = d;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        v[i] = d[WIDTH-1-i];
      end
    end
    return v;
  endfunction

  ser_state_e       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;

  logic             w_hold_full;
  logic [WIDTH-1:0] w_hold_word;
  logic [WIDTH-1:0] w_in_word;
  logic             w_accept;
  logic             w_last;
  logic             w_hold_load;
  logic             w_hold_drain;

  assign w_in_word    = f_order(bus.in_data);
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_last       = (r_state == SER_SHIFT) && (r_cnt == LAST_CNT);

  // A word goes to hold only when the shifter cannot take it at this edge.
  // An accept implies hold is empty, so hold load and drain never coincide.
  assign w_hold_load  = w_accept && (r_state == SER_SHIFT) && !w_last;
  assign w_hold_drain = w_last && w_hold_full;

  seq_skid_reg #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_hold_load),
    .i_drain (w_hold_drain),
    .i_data  (w_in_word),
    .o_full  (w_hold_full),
    .o_data  (w_hold_word)
  );

  // Serializer FSM, bit counter and shifter; reloads on the last bit from
  // hold first, then from the input, otherwise falls back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SER_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        SER_IDLE: begin
          if (w_accept) begin
            r_shift <= w_in_word;
            r_cnt   <= '0;
            r_state <= SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (r_cnt == LAST_CNT) begin
            r_cnt <= '0;
            if (w_hold_full) begin
              r_shift <= w_hold_word;
            end else if (w_accept) begin
              r_shift <= w_in_word;
            end else begin
              r_shift <= '0;
              r_state <= SER_IDLE;
            end
          end else begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= SER_IDLE;
        end
      endcase
    end
  end

  // Ready depends only on hold occupancy and reset, never on in_valid.
  assign bus.in_ready  = !reset && !w_hold_full;
  assign bus.ser_valid = (r_state == SER_SHIFT);
  assign bus.ser_bit   = (r_state == SER_SHIFT) ? r_shift[WIDTH-1] : IDLE_BIT;
  assign bus.ser_last  = w_last;
  assign bus.busy      = (r_state == SER_SHIFT) || w_hold_full;

endmodule : seq_bit_serializer

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: an MSB-first and an LSB-first
// instance, each followed by a small "1001" detector model standing in for
// the downstream sequence detector.
module tb_seq_bit_serializer;
  import seq_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  seq_bit_serializer_if #(.WIDTH(8)) bus8 ();
  seq_bit_serializer_if #(.WIDTH(8)) bus5 ();

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(SEQ_IDLE_BIT)) u_dut_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(SEQ_IDLE_BIT)) u_dut_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5)
  );

  always #5 clk = ~clk;

  // Detector stand-ins: count "1001" over valid serial bits.
  logic [3:0] hist8, hist5;
  int         det8, det5;

  always @(posedge clk) begin
    if (reset) begin
      hist8 <= 4'b0;
      det8  <= 0;
    end else if (bus8.ser_valid) begin
      hist8 <= {hist8[2:0], bus8.ser_bit};
      if ({hist8[2:0], bus8.ser_bit} == 4'b1001) det8 <= det8 + 1;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      hist5 <= 4'b0;
      det5  <= 0;
    end else if (bus5.ser_valid) begin
      hist5 <= {hist5[2:0], bus5.ser_bit};
      if ({hist5[2:0], bus5.ser_bit} == 4'b1001) det5 <= det5 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  w;
    logic [15:0] s2;
    logic [23:0] s3;
    int          d0;

    bus8.in_data  = 8'h00;
    bus8.in_valid = 1'b0;
    bus5.in_data  = 8'h00;
    bus5.in_valid = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_ready",  bus8.in_ready,  1'b0);
    check("rst_valid",  bus8.ser_valid, 1'b0);
    check("rst_bit",    bus8.ser_bit,   SEQ_IDLE_BIT);
    check("rst_last",   bus8.ser_last,  1'b0);
    check("rst_busy",   bus8.busy,      1'b0);
    reset = 1'b0;
    #1;
    check("rst_ready_after", bus8.in_ready, 1'b1);

    // Test 6: idle for 20 cycles
    for (int c = 0; c < 20; c++) begin
      check($sformatf("t6_bit%0d", c),   bus8.ser_bit,   SEQ_IDLE_BIT);
      check($sformatf("t6_valid%0d", c), bus8.ser_valid, 1'b0);
      check($sformatf("t6_ready%0d", c), bus8.in_ready,  1'b1);
      tick();
    end
    check("t6_det", det8, 0);

    // Test 1: 8'h90, MSB first
    w = 8'h90;
    d0 = det8;
    bus8.in_data  = w;
    bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    bus8.in_data  = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_bit%0d", i),   bus8.ser_bit,   w[7-i]);
      check($sformatf("t1_valid%0d", i), bus8.ser_valid, 1'b1);
      check($sformatf("t1_last%0d", i),  bus8.ser_last,  (i == 7));
      tick();
    end
    check("t1_valid_after", bus8.ser_valid, 1'b0);
    check("t1_bit_after",   bus8.ser_bit,   SEQ_IDLE_BIT);
    check("t1_busy_after",  bus8.busy,      1'b0);
    check("t1_det",         det8 - d0,      1);

    // Test 5: 8'h09, LSB first -> 1,0,0,1,0,0,0,0
    w = 8'h90;
    d0 = det5;
    bus5.in_data  = 8'h09;
    bus5.in_valid = 1'b1;
    tick();
    bus5.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5_bit%0d", i),  bus5.ser_bit,  w[7-i]);
      check($sformatf("t5_last%0d", i), bus5.ser_last, (i == 7));
      tick();
    end
    check("t5_valid_after", bus5.ser_valid, 1'b0);
    check("t5_det",         det5 - d0,      1);

    // Test 2: back-to-back 8'h99, 8'hA5 with in_valid held
    s2 = 16'h99A5;
    bus8.in_data  = 8'h99;
    bus8.in_valid = 1'b1;
    fork
      begin
        tick();
        bus8.in_data = 8'hA5;
        tick();
        bus8.in_valid = 1'b0;
      end
      begin
        tick();
        for (int i = 0; i < 16; i++) begin
          check($sformatf("t2_bit%0d", i),   bus8.ser_bit,   s2[15-i]);
          check($sformatf("t2_valid%0d", i), bus8.ser_valid, 1'b1);
          check($sformatf("t2_last%0d", i),  bus8.ser_last,  (i == 7) || (i == 15));
          tick();
        end
      end
    join
    check("t2_valid_after", bus8.ser_valid, 1'b0);

    // Test 3: three words offered on consecutive cycles
    s3 = 24'hC35A0F;
    bus8.in_data  = 8'hC3;
    bus8.in_valid = 1'b1;
    fork
      begin
        tick();
        bus8.in_data = 8'h5A;
        tick();
        bus8.in_data = 8'h0F;
        for (int c = 0; c < 7; c++) begin
          check($sformatf("t3_rdy_low%0d", c), bus8.in_ready, 1'b0);
          check($sformatf("t3_busy%0d", c),    bus8.busy,     1'b1);
          tick();
        end
        check("t3_rdy_high", bus8.in_ready, 1'b1);
        tick();
        bus8.in_valid = 1'b0;
      end
      begin
        tick();
        for (int i = 0; i < 24; i++) begin
          check($sformatf("t3_bit%0d", i),   bus8.ser_bit,   s3[23-i]);
          check($sformatf("t3_valid%0d", i), bus8.ser_valid, 1'b1);
          check($sformatf("t3_last%0d", i),  bus8.ser_last,  (i % 8) == 7);
          tick();
        end
      end
    join
    check("t3_valid_after", bus8.ser_valid, 1'b0);
    check("t3_busy_after",  bus8.busy,      1'b0);

    // Test 4: reset on bit 4 of 8'hFF
    bus8.in_data  = 8'hFF;
    bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("t4_bit4_valid", bus8.ser_valid, 1'b1);
    reset = 1'b1;
    tick();
    check("t4_valid", bus8.ser_valid, 1'b0);
    check("t4_bit",   bus8.ser_bit,   SEQ_IDLE_BIT);
    check("t4_busy",  bus8.busy,      1'b0);
    check("t4_ready_in_rst", bus8.in_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("t4_ready", bus8.in_ready, 1'b1);
    for (int c = 0; c < 8; c++) begin
      check($sformatf("t4_no_resume%0d", c), bus8.ser_valid, 1'b0);
      tick();
    end
    check("t4_ready_later", bus8.in_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_seq_bit_serializer
